// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the RISC-V fetch stage.
//   fetch_state_t      : fetch FSM state encoding
//   RESET_PC_DEFAULT   : text base of the program ROM, first fetch address
//   PC_STEP_DEFAULT    : sequential PC increment in bytes
//   NOP_INSTR          : canonical RV32I NOP (addi x0, x0, 0), handy for benches
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,   // address on the bus, read starts
        ST_WAIT  = 2'd1,   // waiting out ROM latency
        ST_HOLD  = 2'd2,   // instruction register offered to decode
        ST_FAULT = 2'd3    // misaligned redirect target, fetching stopped
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          PC_STEP_DEFAULT  = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_latency_counter.sv
// Loadable down-counter that times ROM read latency.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   clear      : synchronous clear (aborts an in-flight count)
//   load       : load load_value this edge
//   load_value : starting count
//   dec        : decrement this edge (saturates at zero)
//   done       : high while the count sits at 1, i.e. the next
//                decrementing edge is the one on which ROM data is valid
module fetch_latency_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage in front of the program ROM. Owns the PC, drives the ROM
// address, captures the returned word into the instruction register and
// offers it downstream with a valid/ready handshake. Redirects from
// branches/jumps override everything; a misaligned target parks the
// unit in FAULT until an aligned redirect or reset.
//   clk             : system clock, rising edge
//   reset           : asynchronous active-low reset
//   fetch_addr      : ROM byte address (= pc)
//   mem_instruction : word returned by the ROM
//   instr           : instruction register
//   instr_pc        : PC of the word in instr
//   instr_valid     : instr/instr_pc hold a fresh instruction
//   instr_ready     : consumer takes instr this cycle
//   redirect_valid  : load redirect_pc this edge
//   redirect_pc     : branch/jump target
//   misaligned      : sticky, last redirect target had [1:0] != 0
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    MEM_LATENCY = 0,
    parameter int                    PC_STEP     = PC_STEP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] fetch_addr,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  misaligned
);

    localparam int CNT_W = 3;   // covers MEM_LATENCY 0..7

    fetch_state_t          state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [DATA_WIDTH-1:0] instr_pc_reg;
    logic                  instr_valid_reg;
    logic                  misaligned_reg;
    logic                  lat_done;

    generate
        if (MEM_LATENCY == 0) begin : g_no_latency
            // Combinational ROM: ISSUE captures directly, WAIT is never entered.
            assign lat_done = 1'b0;
        end else begin : g_latency
            logic lat_load;
            logic lat_dec;

            // Redirect clears the counter so a discarded read cannot
            // leave a stale count behind.
            assign lat_load = (state_reg == ST_ISSUE) && !redirect_valid;
            assign lat_dec  = (state_reg == ST_WAIT);

            fetch_latency_counter #(
                .CNT_W(CNT_W)
            ) u_lat_cnt (
                .clk        (clk),
                .reset      (reset),
                .clear      (redirect_valid),
                .load       (lat_load),
                .load_value (CNT_W'(MEM_LATENCY)),
                .dec        (lat_dec),
                .done       (lat_done)
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_ISSUE;
            pc_reg          <= RESET_PC;
            instr_reg       <= '0;
            instr_pc_reg    <= RESET_PC;
            instr_valid_reg <= 1'b0;
            misaligned_reg  <= 1'b0;
        end else if (redirect_valid) begin
            // Also completes a pending handshake in HOLD: the word is
            // considered consumed, but pc follows the target.
            pc_reg          <= redirect_pc;
            instr_valid_reg <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                misaligned_reg <= 1'b0;
                state_reg      <= ST_ISSUE;
            end else begin
                misaligned_reg <= 1'b1;
                state_reg      <= ST_FAULT;
            end
        end else begin
            case (state_reg)
                ST_ISSUE: begin
                    if (MEM_LATENCY == 0) begin
                        instr_reg       <= mem_instruction;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ST_HOLD;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_done) begin
                        instr_reg       <= mem_instruction;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        // Wraps modulo 2^DATA_WIDTH with no flag.
                        pc_reg          <= pc_reg + DATA_WIDTH'(PC_STEP);
                        instr_valid_reg <= 1'b0;
                        state_reg       <= ST_ISSUE;
                    end
                end
                ST_FAULT: begin
                    // Parked until an aligned redirect or reset.
                end
                default: begin
                    state_reg <= ST_ISSUE;
                end
            endcase
        end
    end

    assign fetch_addr  = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import riscv_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side ROM contents: NOP at the text base, an address-derived
    // pattern everywhere else so each captured word is distinguishable.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == RPC) ? NOP_INSTR : (a ^ 32'hC0DE_0000);
    endfunction

    // ---------------- DUT with combinational ROM ----------------
    logic        reset0, rdy0, rv0;
    logic [31:0] rpc0, fa0, mi0, instr0, ipc0;
    logic        v0, mis0;

    assign mi0 = rom_word(fa0);

    instruction_fetch_unit #(
        .DATA_WIDTH(32), .RESET_PC(RPC), .MEM_LATENCY(0), .PC_STEP(4)
    ) dut0 (
        .clk(clk), .reset(reset0), .fetch_addr(fa0), .mem_instruction(mi0),
        .instr(instr0), .instr_pc(ipc0), .instr_valid(v0), .instr_ready(rdy0),
        .redirect_valid(rv0), .redirect_pc(rpc0), .misaligned(mis0)
    );

    // ---------------- DUT with 3-cycle ROM latency ----------------
    logic        reset3, rdy3, rv3;
    logic [31:0] rpc3, fa3, mi3, instr3, ipc3;
    logic        v3, mis3;

    assign mi3 = rom_word(fa3);

    instruction_fetch_unit #(
        .DATA_WIDTH(32), .RESET_PC(RPC), .MEM_LATENCY(3), .PC_STEP(4)
    ) dut3 (
        .clk(clk), .reset(reset3), .fetch_addr(fa3), .mem_instruction(mi3),
        .instr(instr3), .instr_pc(ipc3), .instr_valid(v3), .instr_ready(rdy3),
        .redirect_valid(rv3), .redirect_pc(rpc3), .misaligned(mis3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One row per clock edge: inputs applied before the edge, outputs
    // expected just after it.
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] fa;
        logic        v;
        logic [31:0] ipc;
        logic        mis;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] fa, input logic v, input logic [31:0] ipc,
                       input logic mis);
        vecs[nvec] = '{rv, rpc, rdy, fa, v, ipc, mis};
        nvec++;
    endtask

    initial begin
        reset0 = 1'b0; rdy0 = 1'b0; rv0 = 1'b0; rpc0 = '0;
        reset3 = 1'b0; rdy3 = 1'b0; rv3 = 1'b0; rpc3 = '0;

        // Directed vectors for the zero-latency unit.
        add(0, 0, 1, RPC,          1, RPC,          0); // first capture one edge after ISSUE
        add(0, 0, 1, RPC + 4,      0, RPC,          0); // handshake, pc+4
        add(0, 0, 0, RPC + 4,      1, RPC + 4,      0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, RPC + 4,  1, RPC + 4,      0); // backpressure, nothing moves
        add(0, 0, 1, RPC + 8,      0, RPC + 4,      0); // advance exactly once
        add(0, 0, 1, RPC + 8,      1, RPC + 8,      0);
        add(1, 32'h0040_0100, 1, 32'h0040_0100, 0, RPC + 8, 0); // redirect beats pc+4
        add(0, 0, 0, 32'h0040_0100, 1, 32'h0040_0100, 0);
        add(1, 32'h0040_0102, 0, 32'h0040_0102, 0, 32'h0040_0100, 1); // misaligned
        for (int i = 0; i < 10; i++)
            add(0, 0, 1, 32'h0040_0102, 0, 32'h0040_0100, 1); // parked in FAULT
        add(1, 32'h0040_0104, 0, 32'h0040_0104, 0, 32'h0040_0100, 0); // aligned exit
        add(0, 0, 0, 32'h0040_0104, 1, 32'h0040_0104, 0);
        add(1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0040_0104, 0);
        add(0, 0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
        add(0, 0, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 0); // wrap, no flag
        add(0, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 0);

        // Reset state.
        @(posedge clk); #1;
        chk("rst_fa",  fa0,  RPC);
        chk("rst_v",   {31'b0, v0},   0);
        chk("rst_ipc", ipc0, RPC);
        chk("rst_ins", instr0, 0);
        chk("rst_mis", {31'b0, mis0}, 0);
        reset0 = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            rv0 = vecs[i].rv; rpc0 = vecs[i].rpc; rdy0 = vecs[i].rdy;
            @(posedge clk); #1;
            rv0 = 1'b0;
            $display("vec %0d: fa=%08h v=%0b ipc=%08h ins=%08h mis=%0b",
                     i, fa0, v0, ipc0, instr0, mis0);
            chk($sformatf("v%0d_fa", i),  fa0, vecs[i].fa);
            chk($sformatf("v%0d_v", i),   {31'b0, v0}, {31'b0, vecs[i].v});
            chk($sformatf("v%0d_ipc", i), ipc0, vecs[i].ipc);
            chk($sformatf("v%0d_ins", i), instr0, rom_word(vecs[i].ipc));
            chk($sformatf("v%0d_mis", i), {31'b0, mis0}, {31'b0, vecs[i].mis});
        end

        // Asynchronous reset while holding a word: clears without a clock edge.
        rdy0 = 1'b0;
        chk("hold_before_rst", {31'b0, v0}, 1);
        reset0 = 1'b0;
        #1;
        $display("async reset: fa=%08h v=%0b ipc=%08h ins=%08h", fa0, v0, ipc0, instr0);
        chk("arst_v",   {31'b0, v0}, 0);
        chk("arst_fa",  fa0, RPC);
        chk("arst_ipc", ipc0, RPC);
        chk("arst_ins", instr0, 0);
        reset0 = 1'b1;
        @(posedge clk); #1;
        $display("post-reset fetch: v=%0b ipc=%08h ins=%08h", v0, ipc0, instr0);
        chk("prst_v",   {31'b0, v0}, 1);
        chk("prst_ipc", ipc0, RPC);
        chk("prst_ins", instr0, NOP_INSTR);

        // ---------------- latency-3 unit ----------------
        reset3 = 1'b1;   // released between edges: ISSUE now
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            $display("lat3 edge %0d: v=%0b fa=%08h", k, v3, fa3);
            chk($sformatf("lat3_v_e%0d", k), {31'b0, v3}, (k == 4) ? 1 : 0);
        end
        chk("lat3_ipc", ipc3, RPC);
        chk("lat3_ins", instr3, NOP_INSTR);

        rdy3 = 1'b1;
        @(posedge clk); #1;             // handshake -> ISSUE at RPC+4
        rdy3 = 1'b0;
        chk("lat3_hs_fa", fa3, RPC + 4);
        @(posedge clk); #1;             // ISSUE -> WAIT
        @(posedge clk); #1;             // WAIT, read in flight
        chk("lat3_wait_v", {31'b0, v3}, 0);
        rv3 = 1'b1; rpc3 = 32'h0040_0020;
        @(posedge clk); #1;             // redirect discards pending word
        rv3 = 1'b0;
        $display("lat3 redirect: fa=%08h v=%0b mis=%0b", fa3, v3, mis3);
        chk("lat3_rd_fa",  fa3, 32'h0040_0020);
        chk("lat3_rd_v",   {31'b0, v3}, 0);
        chk("lat3_rd_mis", {31'b0, mis3}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            $display("lat3 post-redirect edge %0d: v=%0b ipc=%08h", k, v3, ipc3);
            chk($sformatf("lat3_rd_v_e%0d", k), {31'b0, v3}, (k == 4) ? 1 : 0);
        end
        chk("lat3_rd_ipc", ipc3, 32'h0040_0020);
        chk("lat3_rd_ins", instr3, rom_word(32'h0040_0020));

        // Throughput: handshake then MEM_LATENCY+1 edges to the next word.
        rdy3 = 1'b1;
        @(posedge clk); #1;
        rdy3 = 1'b0;
        chk("lat3_t_v0", {31'b0, v3}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat3_t_v_e%0d", k), {31'b0, v3}, (k == 4) ? 1 : 0);
        end
        $display("lat3 next word: ipc=%08h ins=%08h", ipc3, instr3);
        chk("lat3_t_ipc", ipc3, 32'h0040_0024);
        chk("lat3_t_ins", instr3, rom_word(32'h0040_0024));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
